// File: rtl/quad_encoder_speed.sv
`default_nettype none
// ============================================================================
// Module : quad_encoder_speed
// Brief  : Encoder pin conditioning, x4 quadrature decode and A-period speed
//          measurement with stall and quadrature-error detection.
// Rev    : 1.0  initial release
// ============================================================================
module quad_encoder_speed #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    FILTER_LEN  = 4,
  parameter logic [DATA_WIDTH-1:0] STALL_LIMIT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  encoder_a,
  input  logic                  encoder_b,
  input  logic                  pos_clear,
  output logic [DATA_WIDTH-1:0] period_speed,
  output logic                  period_valid,
  output logic [1:0]            direction,
  output logic [DATA_WIDTH-1:0] position,
  output logic                  stalled,
  output logic                  quad_error
);

  localparam int                    C_FCW  = 4;
  localparam logic [C_FCW-1:0]      C_FMAX = C_FCW'(FILTER_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] C_ONES = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_STALL   = 2'd2
  } state_t;

  logic [1:0] w_pins;
  logic [1:0] w_cur;

  assign w_pins = {encoder_a, encoder_b};

  // Index 1 is pin A, index 0 is pin B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pin
    logic             r_s1;
    logic             r_s2;
    logic             r_filt;
    logic [C_FCW-1:0] r_fcnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_filt <= 1'b0;
        r_fcnt <= '0;
      end else begin
        r_s1 <= w_pins[gi];
        r_s2 <= r_s1;
        if (r_s2 != r_filt) begin
          if (r_fcnt == C_FMAX) begin
            r_filt <= r_s2;
            r_fcnt <= '0;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end else begin
          r_fcnt <= '0;
        end
      end
    end

    assign w_cur[gi] = r_filt;
  end

  logic [1:0]            r_prev;
  logic                  w_fwd;
  logic                  w_rev;
  logic                  w_jump;
  logic                  w_a_rise;

  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    case ({r_prev, w_cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_rev = 1'b1;
      default: ;
    endcase
  end

  assign w_jump   = ((r_prev ^ w_cur) == 2'b11);
  assign w_a_rise = w_cur[1] & ~r_prev[1];

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  w_cnt_clr;
  logic                  w_report;
  logic                  w_stall_enter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_cnt_clr     = 1'b0;
    w_report      = 1'b0;
    w_stall_enter = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_a_rise) begin
          w_next    = S_MEASURE;
          w_cnt_clr = 1'b1;
        end
      end
      S_MEASURE: begin
        // A rise coinciding with the limit still yields a real period.
        if (w_a_rise) begin
          w_report  = 1'b1;
          w_cnt_clr = 1'b1;
        end else if (r_cnt == STALL_LIMIT) begin
          w_next        = S_STALL;
          w_stall_enter = 1'b1;
        end
      end
      S_STALL: begin
        if (w_a_rise) begin
          w_next    = S_MEASURE;
          w_cnt_clr = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] r_period;
  logic                  r_valid;
  logic [1:0]            r_dir;
  logic [DATA_WIDTH-1:0] r_pos;
  logic                  r_stalled;
  logic                  r_qerr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= 2'b00;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_dir     <= 2'b00;
      r_pos     <= '0;
      r_stalled <= 1'b0;
      r_qerr    <= 1'b0;
    end else begin
      r_prev    <= w_cur;
      r_qerr    <= w_jump;
      r_valid   <= w_report | w_stall_enter;
      r_stalled <= (w_next == S_STALL);

      if (w_cnt_clr)                 r_cnt <= '0;
      else if (r_cnt != STALL_LIMIT) r_cnt <= r_cnt + 1'b1;

      if (w_report)           r_period <= (r_cnt == C_ONES) ? r_cnt : r_cnt + 1'b1;
      else if (w_stall_enter) r_period <= STALL_LIMIT;

      if (pos_clear)  r_pos <= '0;
      else if (w_fwd) r_pos <= r_pos + 1'b1;
      else if (w_rev) r_pos <= r_pos - 1'b1;

      if (w_fwd)              r_dir <= 2'b10;
      else if (w_rev)         r_dir <= 2'b01;
      else if (w_stall_enter) r_dir <= 2'b00;
    end
  end

  assign period_speed = r_period;
  assign period_valid = r_valid;
  assign direction    = r_dir;
  assign position     = r_pos;
  assign stalled      = r_stalled;
  assign quad_error   = r_qerr;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_speed.sv
`default_nettype none
// ============================================================================
// Module : tb_quad_encoder_speed
// Brief  : Directed scoreboard bench for quad_encoder_speed.
// Rev    : 1.0  initial release
// ============================================================================
module tb_quad_encoder_speed;

  localparam int          DW    = 16;
  localparam logic [15:0] LIMIT = 16'd1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          encoder_a;
  logic          encoder_b;
  logic          pos_clear;
  logic [DW-1:0] period_speed;
  logic          period_valid;
  logic [1:0]    direction;
  logic [DW-1:0] position;
  logic          stalled;
  logic          quad_error;

  quad_encoder_speed #(
    .DATA_WIDTH (DW),
    .FILTER_LEN (4),
    .STALL_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .encoder_a   (encoder_a),
    .encoder_b   (encoder_b),
    .pos_clear   (pos_clear),
    .period_speed(period_speed),
    .period_valid(period_valid),
    .direction   (direction),
    .position    (position),
    .stalled     (stalled),
    .quad_error  (quad_error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  int          exp_q[$];
  logic [1:0]  m_ab    = 2'b00;
  logic [15:0] m_pos   = 16'd0;
  int          m_state = 0;  // 0 idle, 1 measuring, 2 stalled
  int          m_last  = 0;

  logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (period_valid === 1'b1) begin
        vld_cnt++;
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("period_speed", 32'(period_speed), exp_q.pop_front());
      end
      if (quad_error === 1'b1) err_cnt++;
    end
  end

  // Drives a new pin pair and advances the reference model of position and period.
  task automatic drive(input logic [1:0] ab);
    logic [1:0] prev;
    @(posedge clk); #2;
    prev      = m_ab;
    m_ab      = ab;
    encoder_a = ab[1];
    encoder_b = ab[0];
    case ({prev, ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: m_pos = m_pos + 16'd1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: m_pos = m_pos - 16'd1;
      default: ;
    endcase
    if (!prev[1] && ab[1]) begin
      if (m_state == 1) exp_q.push_back(cyc - m_last);
      m_state = 1;
      m_last  = cyc;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int e0;
    int t;
    reset     = 1'b1;
    encoder_a = 1'b0;
    encoder_b = 1'b0;
    pos_clear = 1'b0;
    wait_cyc(3);
    #1;
    check("rst_period", 32'(period_speed), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_dir", 32'(direction), 32'd0);
    check("rst_pos", 32'(position), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd0);
    check("rst_qerr", 32'(quad_error), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Forward rotation, A rise every 400 cycles.
    for (int i = 0; i < 12; i++) begin
      drive(fwd_seq[i % 4]);
      wait_cyc(99);
      if (i == 3) check("no_valid_first_rise", 32'(vld_cnt), 32'd0);
    end
    settle();
    check("fwd_pos", 32'(position), 32'(m_pos));
    check("fwd_pos_abs", 32'(position), 32'd12);
    check("fwd_dir", 32'(direction), 32'b10);
    check("fwd_period", 32'(period_speed), 32'd400);
    check("fwd_valids", 32'(vld_cnt), 32'd2);

    // Reversal must be seen within 2+FILTER_LEN+1 cycles of the pin edge.
    drive(rev_seq[0]);
    wait_cyc(7);
    #1;
    check("rev_dir_latency", 32'(direction), 32'b01);
    check("rev_pos_latency", 32'(position), 32'd11);
    wait_cyc(92);
    for (int i = 1; i < 8; i++) begin
      drive(rev_seq[i % 4]);
      wait_cyc(99);
    end
    settle();
    check("rev_pos", 32'(position), 32'd4);
    check("rev_dir", 32'(direction), 32'b01);

    // Three-cycle glitches on A are rejected.
    v0 = vld_cnt;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #2;
      encoder_a = 1'b1;
      wait_cyc(3);
      #2;
      encoder_a = 1'b0;
      wait_cyc(20);
    end
    settle();
    check("glitch_pos", 32'(position), 32'd4);
    check("glitch_valids", 32'(vld_cnt), 32'(v0));

    // Illegal 00 -> 11 jump.
    e0 = err_cnt;
    drive(2'b11);
    settle();
    check("jump_qerr_once", 32'(err_cnt), 32'(e0 + 1));
    check("jump_pos", 32'(position), 32'd4);
    check("jump_dir", 32'(direction), 32'b01);

    // Stall after LIMIT cycles without an A rise.
    v0 = vld_cnt;
    exp_q.push_back(int'(LIMIT));
    m_state = 2;
    t = 0;
    while (stalled !== 1'b1 && t < 1300) begin
      @(posedge clk); #1;
      t++;
    end
    check("stall_seen", 32'(stalled), 32'd1);
    check("stall_period", 32'(period_speed), 32'(LIMIT));
    check("stall_dir", 32'(direction), 32'b00);
    wait_cyc(20);
    #1;
    check("stall_one_valid", 32'(vld_cnt), 32'(v0 + 1));
    v0 = vld_cnt;
    drive(2'b10); wait_cyc(99);
    drive(2'b00); wait_cyc(99);
    drive(2'b01); wait_cyc(99);
    drive(2'b11);
    settle();
    check("resume_unstall", 32'(stalled), 32'd0);
    check("resume_no_valid", 32'(vld_cnt), 32'(v0));
    wait_cyc(89);
    drive(2'b10); wait_cyc(99);
    drive(2'b00); wait_cyc(99);
    drive(2'b01); wait_cyc(99);
    drive(2'b11);
    settle();
    check("resume_period", 32'(period_speed), 32'd400);
    check("resume_pos", 32'(position), 32'(m_pos));
    check("resume_dir", 32'(direction), 32'b10);

    // pos_clear coinciding with a forward count.
    drive(2'b10);
    wait_cyc(6);
    #2;
    pos_clear = 1'b1;
    @(posedge clk); #2;
    pos_clear = 1'b0;
    m_pos = 16'd0;
    settle();
    check("clear_wins", 32'(position), 32'd0);
    drive(2'b00);
    settle();
    check("post_clear_count", 32'(position), 32'd1);

    // Asynchronous reset in the middle of a measurement.
    wait_cyc(50);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_period", 32'(period_speed), 32'd0);
    check("mid_rst_dir", 32'(direction), 32'd0);
    check("mid_rst_pos", 32'(position), 32'd0);
    check("mid_rst_stalled", 32'(stalled), 32'd0);
    exp_q.delete();
    m_state = 0;
    m_pos   = 16'd0;
    @(posedge clk); #2;
    reset = 1'b0;
    v0 = vld_cnt;
    drive(2'b01); wait_cyc(99);
    drive(2'b11);
    settle();
    check("rearm_period_zero", 32'(period_speed), 32'd0);
    check("rearm_no_valid", 32'(vld_cnt), 32'(v0));
    wait_cyc(89);
    drive(2'b10); wait_cyc(99);
    drive(2'b00); wait_cyc(99);
    drive(2'b01); wait_cyc(99);
    drive(2'b11);
    settle();
    check("rearm_period", 32'(period_speed), 32'd400);
    check("rearm_valid", 32'(vld_cnt), 32'(v0 + 1));
    check("rearm_pos", 32'(position), 32'd6);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
